// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, DRAM wait freeze,
// operand forwarding selects, stall statistics and DRAM timeout detection.
module pipe_hazard_ctrl #(
    parameter int LU_CYCLES   = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_re1,
    input  logic        id_re2,
    input  logic [4:0]  ex_wR,
    input  logic        ex_rf_we,
    input  logic [1:0]  ex_wd_sel,
    input  logic [4:0]  mem_wR,
    input  logic [4:0]  wb_wR,
    input  logic        mem_rf_we,
    input  logic        wb_rf_we,
    input  logic        ex_br_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt,
    output logic        mem_err
);

    typedef enum logic [1:0] {RUN, LU, MEMW} state_e;

    localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

    state_e      state_q, state_d, eff;
    logic        lu_pend_q, lu_pend_d;
    logic [15:0] wait_q, wait_d;
    logic        err_q, err_d;
    logic [15:0] scnt_q, scnt_d;
    logic        freeze, lu;

    assign freeze = mem_req & ~mem_ack;
    assign lu     = ex_rf_we & (ex_wd_sel == 2'b01) & (ex_wR != 5'd0) &
                    ((id_re1 & (id_rs1 == ex_wR)) | (id_re2 & (id_rs2 == ex_wR)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            lu_pend_q <= 1'b0;
            wait_q    <= 16'd0;
            err_q     <= 1'b0;
            scnt_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            lu_pend_q <= lu_pend_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            scnt_q    <= scnt_d;
        end
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        state_d      = RUN;
        lu_pend_d    = 1'b0;
        wait_d       = wait_q;
        err_d        = err_q;
        // MEMW remembers an interrupted LU extension so it resumes on release
        eff = (state_q == MEMW) ? (lu_pend_q ? LU : RUN) : state_q;

        if (freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            state_d      = MEMW;
            lu_pend_d    = (eff == LU);
            if (state_q != MEMW)
                wait_d = 16'd1;
            else if (wait_q != 16'hFFFF)
                wait_d = wait_q + 16'd1;
            if (wait_d >= TMO)
                err_d = 1'b1;
        end else if (ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (eff == LU || lu) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = (eff == RUN && LU_CYCLES == 2) ? LU : RUN;
        end

        scnt_d = (pc_stall && scnt_q != 16'hFFFF) ? scnt_q + 16'd1 : scnt_q;

        // outputs go quiet the instant reset asserts, independent of inputs
        if (!rst_n) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            id_ex_stall  = 1'b0;
            ex_mem_stall = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
        end
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_rf_we && mem_wR != 5'd0 && mem_wR == id_rs1)   fwd_a = 2'b01;
        else if (wb_rf_we && wb_wR != 5'd0 && wb_wR == id_rs1) fwd_a = 2'b10;
        if (mem_rf_we && mem_wR != 5'd0 && mem_wR == id_rs2)   fwd_b = 2'b01;
        else if (wb_rf_we && wb_wR != 5'd0 && wb_wR == id_rs2) fwd_b = 2'b10;
        if (!rst_n) begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end
    end

    assign stall_cnt = scnt_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: dut2 uses a 2-cycle load-use stall and 4-cycle DRAM timeout,
// dut1 the single-cycle stall and default timeout, both on shared stimulus.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0, rst_n;
    logic [4:0] id_rs1, id_rs2, ex_wR, mem_wR, wb_wR;
    logic id_re1, id_re2, ex_rf_we, mem_rf_we, wb_rf_we, ex_br_taken, mem_req, mem_ack;
    logic [1:0] ex_wd_sel;

    logic pc2, ifs2, ids2, exs2, iff2, idf2, err2;
    logic pc1, ifs1, ids1, exs1, iff1, idf1, err1;
    logic [1:0] fa2, fb2, fa1, fb1;
    logic [15:0] sc2, sc1;
    logic [5:0] c2, c1;

    localparam logic [5:0] NONE = 6'b000000, LUS = 6'b110001,
                           FRZ  = 6'b111100, BRF = 6'b000011;

    int checks = 0, errors = 0;
    logic [15:0] exp2 = 16'd0, exp1 = 16'd0;

    assign c2 = {pc2, ifs2, ids2, exs2, iff2, idf2};
    assign c1 = {pc1, ifs1, ids1, exs1, iff1, idf1};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LU_CYCLES(2), .MEM_TIMEOUT(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1),
        .id_re2(id_re2), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel),
        .mem_wR(mem_wR), .wb_wR(wb_wR), .mem_rf_we(mem_rf_we), .wb_rf_we(wb_rf_we),
        .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_stall(pc2), .if_id_stall(ifs2), .id_ex_stall(ids2), .ex_mem_stall(exs2),
        .if_id_flush(iff2), .id_ex_flush(idf2), .fwd_a(fa2), .fwd_b(fb2),
        .stall_cnt(sc2), .mem_err(err2));

    pipe_hazard_ctrl #(.LU_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1),
        .id_re2(id_re2), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel),
        .mem_wR(mem_wR), .wb_wR(wb_wR), .mem_rf_we(mem_rf_we), .wb_rf_we(wb_rf_we),
        .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_stall(pc1), .if_id_stall(ifs1), .id_ex_stall(ids1), .ex_mem_stall(exs1),
        .if_id_flush(iff1), .id_ex_flush(idf1), .fwd_a(fa1), .fwd_b(fb1),
        .stall_cnt(sc1), .mem_err(err1));

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; id_re1 = 0; id_re2 = 0; ex_wR = 0; ex_rf_we = 0;
        ex_wd_sel = 0; mem_wR = 0; wb_wR = 0; mem_rf_we = 0; wb_rf_we = 0;
        ex_br_taken = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic set_lu();
        ex_rf_we = 1; ex_wd_sel = 2'b01; ex_wR = 5'd5; id_rs1 = 5'd5; id_re1 = 1;
    endtask

    // advance one clock; s2/s1 are the pc_stall values expected before the edge
    task automatic tick(input bit s2, input bit s1);
        @(posedge clk); #1;
        if (s2 && exp2 != 16'hFFFF) exp2++;
        if (s1 && exp1 != 16'hFFFF) exp1++;
    endtask

    task automatic test_reset();
        rst_n = 0; clr(); set_lu(); mem_req = 1; mem_rf_we = 1; mem_wR = 5'd5;
        #1;
        checks++; if (c2 !== NONE || c1 !== NONE) begin errors++;
            $display("FAIL reset_ctl: got %b/%b want %b", c2, c1, NONE); end
        checks++; if (fa2 !== 2'b00 || sc2 !== 16'd0 || err2 !== 1'b0) begin errors++;
            $display("FAIL reset_state: fwd_a=%b cnt=%0d err=%b want 0", fa2, sc2, err2); end
        clr();
        @(posedge clk); #1; rst_n = 1;
        tick(0, 0);
    endtask

    task automatic test_load_use();
        clr(); set_lu(); #1;
        checks++; if (c2 !== LUS || c1 !== LUS) begin errors++;
            $display("FAIL lu_first: got %b/%b want %b", c2, c1, LUS); end
        tick(1, 1);
        clr(); #1;
        checks++; if (c2 !== LUS || c1 !== NONE) begin errors++;
            $display("FAIL lu_second: got %b/%b want %b/%b", c2, c1, LUS, NONE); end
        tick(1, 0);
        checks++; if (c2 !== NONE) begin errors++;
            $display("FAIL lu_done: got %b want %b", c2, NONE); end
        checks++; if (sc2 !== exp2 || sc1 !== exp1) begin errors++;
            $display("FAIL lu_cnt: got %0d/%0d want %0d/%0d", sc2, sc1, exp2, exp1); end
    endtask

    task automatic test_hazard_table();
        // {we, wd_sel, ex_wR, rs1, re1, rs2, re2, stall}
        logic [22:0] tbl [5];
        tbl[0] = {1'b1, 2'b01, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0};
        tbl[1] = {1'b1, 2'b01, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[2] = {1'b1, 2'b00, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0};
        tbl[3] = {1'b1, 2'b01, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1, 1'b1};
        tbl[4] = {1'b0, 2'b01, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            logic [5:0] e;
            clr();
            {ex_rf_we, ex_wd_sel, ex_wR, id_rs1, id_re1, id_rs2, id_re2} = tbl[i][22:1];
            e = tbl[i][0] ? LUS : NONE;
            #1;
            checks++; if (c2 !== e || c1 !== e) begin errors++;
                $display("FAIL haz_vec%0d: got %b/%b want %b", i, c2, c1, e); end
            tick(tbl[i][0], tbl[i][0]);
            clr();
            if (tbl[i][0]) tick(1, 0);
        end
    endtask

    task automatic test_branch();
        clr(); set_lu(); ex_br_taken = 1; #1;
        checks++; if (c2 !== BRF || c1 !== BRF) begin errors++;
            $display("FAIL br_over_lu: got %b/%b want %b", c2, c1, BRF); end
        tick(0, 0);
        clr(); #1;
        checks++; if (c2 !== NONE) begin errors++;
            $display("FAIL br_stay_run: got %b want %b", c2, NONE); end
        set_lu(); #1;
        tick(1, 1);
        clr(); ex_br_taken = 1; #1;
        checks++; if (c2 !== BRF) begin errors++;
            $display("FAIL br_over_LU: got %b want %b", c2, BRF); end
        tick(0, 0);
        clr(); #1;
        checks++; if (c2 !== NONE) begin errors++;
            $display("FAIL br_LU_exit: got %b want %b", c2, NONE); end
        tick(0, 0);
    endtask

    task automatic test_memwait();
        clr(); mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (c2 !== FRZ || c1 !== FRZ) begin errors++;
                $display("FAIL mw_cyc%0d: got %b/%b want %b", i, c2, c1, FRZ); end
            tick(1, 1);
        end
        mem_ack = 1; #1;
        checks++; if (c2 !== NONE || c1 !== NONE) begin errors++;
            $display("FAIL mw_ack: got %b/%b want %b", c2, c1, NONE); end
        tick(0, 0);
        clr(); #1;
        checks++; if (err2 !== 1'b0 || sc2 !== exp2 || sc1 !== exp1) begin errors++;
            $display("FAIL mw_stats: err=%b cnt=%0d/%0d want 0 %0d/%0d", err2, sc2, sc1, exp2, exp1); end
        // freeze outranks branch and load-use; branch takes over once acked
        set_lu(); ex_br_taken = 1; mem_req = 1; #1;
        checks++; if (c2 !== FRZ) begin errors++;
            $display("FAIL mw_prio: got %b want %b", c2, FRZ); end
        tick(1, 1);
        mem_ack = 1; #1;
        checks++; if (c2 !== BRF) begin errors++;
            $display("FAIL mw_then_br: got %b want %b", c2, BRF); end
        tick(0, 0);
        clr();
    endtask

    task automatic test_lu_frozen();
        clr(); set_lu(); #1;
        tick(1, 1);
        clr(); mem_req = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (c2 !== FRZ) begin errors++;
                $display("FAIL luf_frz%0d: got %b want %b", i, c2, FRZ); end
            tick(1, 1);
        end
        mem_req = 0; #1;
        checks++; if (c2 !== LUS || c1 !== NONE) begin errors++;
            $display("FAIL luf_resume: got %b/%b want %b/%b", c2, c1, LUS, NONE); end
        tick(1, 0);
        checks++; if (c2 !== NONE) begin errors++;
            $display("FAIL luf_done: got %b want %b", c2, NONE); end
        tick(0, 0);
    endtask

    task automatic test_forward();
        // {mem_we, mem_wR, wb_we, wb_wR, rs1, rs2, mem_req, fa, fb}
        logic [27:0] tbl [6];
        tbl[0] = {1'b1, 5'd7, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 2'b00, 2'b01};
        tbl[1] = {1'b0, 5'd7, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 2'b10, 2'b10};
        tbl[2] = {1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00};
        tbl[3] = {1'b1, 5'd3, 1'b1, 5'd4, 5'd3, 5'd4, 1'b0, 2'b01, 2'b10};
        tbl[4] = {1'b1, 5'd3, 1'b0, 5'd4, 5'd4, 5'd3, 1'b0, 2'b00, 2'b01};
        tbl[5] = {1'b1, 5'd3, 1'b1, 5'd4, 5'd4, 5'd3, 1'b1, 2'b10, 2'b01};
        for (int i = 0; i < 6; i++) begin
            clr();
            {mem_rf_we, mem_wR, wb_rf_we, wb_wR, id_rs1, id_rs2, mem_req} = tbl[i][27:4];
            #1;
            checks++; if (fa2 !== tbl[i][3:2] || fb2 !== tbl[i][1:0] || fb1 !== tbl[i][1:0]) begin
                errors++;
                $display("FAIL fwd_vec%0d: got a=%b b=%b/%b want a=%b b=%b",
                         i, fa2, fb2, fb1, tbl[i][3:2], tbl[i][1:0]); end
        end
        clr(); #1;
    endtask

    task automatic test_timeout();
        clr(); mem_req = 1;
        tick(1, 1); tick(1, 1); tick(1, 1);
        checks++; if (err2 !== 1'b0) begin errors++;
            $display("FAIL to_early: got %b want 0", err2); end
        tick(1, 1);
        checks++; if (err2 !== 1'b1 || err1 !== 1'b0 || c2 !== FRZ) begin errors++;
            $display("FAIL to_set: err=%b/%b ctl=%b want 1/0 %b", err2, err1, c2, FRZ); end
        mem_ack = 1; #1;
        tick(0, 0);
        clr(); tick(0, 0);
        checks++; if (err2 !== 1'b1) begin errors++;
            $display("FAIL to_sticky: got %b want 1", err2); end
        checks++; if (sc2 !== exp2) begin errors++;
            $display("FAIL to_cnt: got %0d want %0d", sc2, exp2); end
        rst_n = 0; #1;
        checks++; if (err2 !== 1'b0 || sc2 !== 16'd0) begin errors++;
            $display("FAIL to_rst: err=%b cnt=%0d want 0 0", err2, sc2); end
        exp2 = 0; exp1 = 0;
        rst_n = 1;
        tick(0, 0);
    endtask

    task automatic test_reset_mid();
        clr(); set_lu(); #1;
        tick(1, 1);
        rst_n = 0; #1;
        checks++; if (c2 !== NONE || c1 !== NONE || sc2 !== 16'd0) begin errors++;
            $display("FAIL rstlu_async: got %b/%b cnt=%0d want 0", c2, c1, sc2); end
        exp2 = 0; exp1 = 0;
        clr(); rst_n = 1; #1;
        tick(0, 0);
        checks++; if (c2 !== NONE) begin errors++;
            $display("FAIL rstlu_after: got %b want %b", c2, NONE); end
        set_lu(); #1;
        tick(1, 1);
        clr(); mem_req = 1; #1;
        tick(1, 1);
        rst_n = 0; #1;
        checks++; if (c2 !== NONE || c1 !== NONE) begin errors++;
            $display("FAIL rstmw_async: got %b/%b want 0", c2, c1); end
        exp2 = 0; exp1 = 0;
        clr(); rst_n = 1; #1;
        checks++; if (c2 !== NONE) begin errors++;
            $display("FAIL rstmw_rel: got %b want %b", c2, NONE); end
        tick(0, 0);
        checks++; if (c2 !== NONE || sc2 !== exp2) begin errors++;
            $display("FAIL rstmw_after: got %b cnt=%0d want %b %0d", c2, sc2, NONE, exp2); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_hazard_table();
        test_branch();
        test_memwait();
        test_lu_frozen();
        test_forward();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter LU_CYCLES, default 1, load-use stall length in cycles; legal values 1 or 2.
REQ-002 Parameter MEM_TIMEOUT, default 255, maximum DRAM wait cycles before an error is flagged; range 1..65535.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-006 id_re1, id_re2  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-007 ex_wR  in  5  destination register in EX.
REQ-008 ex_rf_we  in  1  EX writes the register file.
REQ-009 ex_wd_sel  in  2  EX write-data select; 2'b01 means DRAM load data.
REQ-010 mem_wR, wb_wR  in  5 each  destination register in MEM / WB.
REQ-011 mem_rf_we, wb_rf_we  in  1 each  MEM / WB write the register file.
REQ-012 ex_br_taken  in  1  branch or jump resolved taken in EX.
REQ-013 mem_req  in  1  EX/MEM holds a DRAM access (load or store).
REQ-014 mem_ack  in  1  DRAM completes the access this cycle.
REQ-015 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the PC / pipeline register.
REQ-016 if_id_flush, id_ex_flush  out  1 each  load a bubble (all-zero controls) into IF/ID / ID/EX.
REQ-017 fwd_a, fwd_b  out  2 each  operand source for rs1 / rs2: 00 = register file, 01 = MEM stage, 10 = WB stage.
REQ-018 stall_cnt  out  16  saturating count of cycles with pc_stall asserted.
REQ-019 mem_err  out  1  sticky DRAM timeout flag.

Function
REQ-020 FSM states: RUN, LU (load-use extension), MEMW (DRAM wait); reset state is RUN.
REQ-021 freeze = mem_req & ~mem_ack, in any state; while freeze is 1, all four stall outputs are 1, both flush outputs are 0, and the FSM is in or enters MEMW.
REQ-022 MEMW -> RUN on the cycle freeze is 0; LU progress is frozen while in MEMW and resumes afterwards.
REQ-023 Load-use hazard (lu) = ex_rf_we & ex_wd_sel==2'b01 & ex_wR!=0 & ((id_re1 & id_rs1==ex_wR) | (id_re2 & id_rs2==ex_wR)).
REQ-024 When lu is 1 and freeze and ex_br_taken are 0: pc_stall=1, if_id_stall=1, id_ex_flush=1, id_ex_stall=0, ex_mem_stall=0.
REQ-025 If LU_CYCLES=2, the first lu cycle moves RUN -> LU; LU repeats the REQ-024 outputs for exactly one more cycle regardless of lu, then returns to RUN.
REQ-026 When ex_br_taken is 1 and freeze is 0: if_id_flush=1, id_ex_flush=1, and all stall outputs are 0; this overrides lu and the LU state (LU -> RUN).
REQ-027 Priority: freeze > ex_br_taken > LU/lu > normal flow; normal flow drives all stall and flush outputs to 0.
REQ-028 fwd_a = 01 if mem_rf_we & mem_wR!=0 & mem_wR==id_rs1; else 10 if wb_rf_we & wb_wR!=0 & wb_wR==id_rs1; else 00. fwd_b follows the same rule with id_rs2. The MEM match wins over the WB match.
REQ-029 Forwarding outputs are combinational and are not affected by stalls or flushes.
REQ-030 A 16-bit wait counter clears on entering MEMW and increments each MEMW cycle. When it reaches MEM_TIMEOUT, mem_err sets and stays set until reset; the stall continues.
REQ-031 stall_cnt increments on every cycle with pc_stall=1 and saturates at 16'hFFFF.
REQ-032 Register x0 never causes a hazard or a forward.

Reset
REQ-033 While rst_n=0: state=RUN, wait counter=0, stall_cnt=0, mem_err=0, and all stall, flush and fwd outputs are 0.
REQ-034 Reset asserted mid-MEMW or mid-LU aborts the sequence immediately, with no residual stall after rst_n rises.

Verification
REQ-035 ex_wd_sel=01, ex_rf_we=1, ex_wR=5, id_rs1=5, id_re1=1, LU_CYCLES=2 -> pc_stall/if_id_stall/id_ex_flush =1 for exactly 2 cycles, then 0; stall_cnt increases by 2.
REQ-036 mem_req=1 with mem_ack low for 3 cycles, then high -> all four stalls =1 for 3 cycles and 0 on the ack cycle; flushes stay 0.
REQ-037 ex_br_taken=1 together with a load-use hazard -> if_id_flush=id_ex_flush=1, pc_stall=0, state stays RUN.
REQ-038 mem_wR=wb_wR=7, both we=1, id_rs2=7 -> fwd_b=01; clear mem_rf_we -> fwd_b=10; id_rs2=0 with all wR=0 -> fwd_b=00.
REQ-039 MEM_TIMEOUT=4, mem_ack held low -> mem_err=1 after the 4th MEMW cycle and stays 1 after ack; rst_n pulse clears it.
REQ-040 rst_n low during LU or MEMW -> all outputs 0 asynchronously, and the next cycle after release has no stall.
